sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock FIFO, parametrised successor of the async_fifo: arbitrary depth (non-power-of-two allowed),
//  programmable almost-full/almost-empty thresholds, exact fill level, selectable standard/FWFT read mode,
//  sticky overflow/underflow error flags. Used for same-domain buffering where CDC logic is not needed.
// PARAMETERS
//  BITS           32        width of each entry
//  SIZE           16        number of entries, >= 2, any integer
//  AFULL_THRESH   SIZE-2    p_write_almost_full asserts when level >= AFULL_THRESH (1..SIZE)
//  AEMPTY_THRESH  2         p_read_almost_empty asserts when level <= AEMPTY_THRESH (0..SIZE-1)
//  FWFT           0         0 = standard registered read, 1 = first-word-fall-through
// PORTS
//  clk                  in   1                  clock, all logic on rising edge
//  rst_n                in   1                  asynchronous active-low reset
//  p_write_en           in   1                  write request
//  p_write_data         in   BITS               data to write
//  p_write_full         out  1                  level == SIZE
//  p_write_almost_full  out  1                  level >= AFULL_THRESH
//  p_read_en            in   1                  read request
//  p_read_data          out  BITS               read data
//  p_read_empty         out  1                  level == 0
//  p_read_almost_empty  out  1                  level <= AEMPTY_THRESH
//  p_level              out  $clog2(SIZE+1)     current entry count
//  p_overflow           out  1                  sticky: write attempted while full
//  p_underflow          out  1                  sticky: read attempted while empty
//  p_clear_err          in   1                  synchronous clear of p_overflow/p_underflow
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, p_read_data=0, overflow=underflow=0. Memory array not reset; contents discarded.
//  - Reset mid-operation: all in-flight data lost; first post-reset write is the new head.
//  - Write accepted iff p_write_en && !p_write_full; mem[wr_ptr]<=data, wr_ptr advances.
//  - Read accepted iff p_read_en && !p_read_empty; rd_ptr advances.
//  - Pointers range 0..SIZE-1, wrap SIZE-1 -> 0 (explicit compare, no power-of-two masking).
//  - level: +1 write only, -1 read only, unchanged when both or neither accepted.
//  - Simultaneous write+read: when full, read accepted, write rejected (overflow set), level -> SIZE-1;
//    when empty, write accepted, read rejected (underflow set), level -> 1. Never bypass.
//  - All status flags decoded from registered level only; no combinational path from p_write_en/p_read_en.
//  - FWFT=0: p_read_data <= mem[rd_ptr] on accepted read; valid the cycle after; holds otherwise.
//  - FWFT=1: p_read_data = mem[rd_ptr] while !empty (head visible one cycle after the write into an
//    empty FIFO); accepted read pops, next entry visible same cycle after the edge; 0 while empty.
//  - Sticky errors: set on rejected request, cleared by p_clear_err; set wins over clear same cycle.
//  - Elaboration $fatal if SIZE<2, AFULL_THRESH outside 1..SIZE, AEMPTY_THRESH outside 0..SIZE-1.
// TESTING (BITS=32, SIZE=16 unless stated)
//  1 Fill/drain: 16 writes of 32'hA000_0000+i -> almost_full after 14th, full after 16th, level=16;
//    17th write -> overflow=1, level stays 16; 16 reads return A000_0000..A000_000F in order, empty=1.
//  2 Simultaneous: at level 5 write+read -> level stays 5, order kept; at full write+read -> level 15,
//    overflow=1, rejected word never read out.
//  3 Underflow: read when empty -> underflow=1, p_read_data unchanged, level 0; p_clear_err -> 0;
//    clear and new underflow same cycle -> stays 1.
//  4 Reset mid-burst: rst_n low after 7 writes -> same instant empty=1, full=0, level=0, p_read_data=0;
//    after release write 32'h55 then read -> 32'h55.
//  5 FWFT=1: write 32'h1234 into empty -> next cycle empty=0, p_read_data=32'h1234 without read_en;
//    write 32'h5678, read -> p_read_data=32'h5678 next cycle.
//  6 SIZE=5, AFULL_THRESH=4, AEMPTY_THRESH=1: 40 random interleaved ops vs scoreboard -> ordering
//    preserved across >=5 pointer wraps, flags match model level every cycle.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty thresholds,
// exact fill level, standard or first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int BITS          = 32,
    parameter int SIZE          = 16,
    parameter int AFULL_THRESH  = SIZE - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p_write_en,
    input  logic [BITS-1:0]           p_write_data,
    output logic                      p_write_full,
    output logic                      p_write_almost_full,
    input  logic                      p_read_en,
    output logic [BITS-1:0]           p_read_data,
    output logic                      p_read_empty,
    output logic                      p_read_almost_empty,
    output logic [$clog2(SIZE+1)-1:0] p_level,
    output logic                      p_overflow,
    output logic                      p_underflow,
    input  logic                      p_clear_err
);

    localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int LW = $clog2(SIZE + 1);

    if (SIZE < 2) begin : g_bad_size
        $fatal(1, "sync_fifo_flags: SIZE must be >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > SIZE)) begin : g_bad_afull
        $fatal(1, "sync_fifo_flags: AFULL_THRESH must be in 1..SIZE");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > SIZE - 1)) begin : g_bad_aempty
        $fatal(1, "sync_fifo_flags: AEMPTY_THRESH must be in 0..SIZE-1");
    end

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(SIZE - 1)) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    logic [BITS-1:0] r_mem [SIZE];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_full;
    logic            r_almost_full;
    logic            r_empty;
    logic            r_almost_empty;
    logic [BITS-1:0] r_read_data;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;
    logic [LW-1:0]   w_level_nxt;
    logic [BITS-1:0] w_head_nxt;
    logic [BITS-1:0] w_read_data_nxt;

    assign w_wr_acc = p_write_en && !r_full;
    assign w_rd_acc = p_read_en && !r_empty;

    // Next pointers, level and read-data value.
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_level_nxt     = r_level;
        w_head_nxt      = {BITS{1'b0}};
        w_read_data_nxt = r_read_data;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
        // A write landing on the slot that becomes the head is seen through the write port.
        if (w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = p_write_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
        if (FWFT != 0) begin
            w_read_data_nxt = (w_level_nxt == {LW{1'b0}}) ? {BITS{1'b0}} : w_head_nxt;
        end else if (w_rd_acc) begin
            w_read_data_nxt = r_mem[r_rd_ptr];
        end else begin
            w_read_data_nxt = r_read_data;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= p_write_data;
        end
    end

    // Pointers, level, status flags, read data and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= {PW{1'b0}};
            r_rd_ptr       <= {PW{1'b0}};
            r_level        <= {LW{1'b0}};
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_read_data    <= {BITS{1'b0}};
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LW'(SIZE));
            r_almost_full  <= (w_level_nxt >= LW'(AFULL_THRESH));
            r_empty        <= (w_level_nxt == {LW{1'b0}});
            r_almost_empty <= (w_level_nxt <= LW'(AEMPTY_THRESH));
            r_read_data    <= w_read_data_nxt;
            r_overflow     <= (p_write_en && r_full) ? 1'b1 : (p_clear_err ? 1'b0 : r_overflow);
            r_underflow    <= (p_read_en && r_empty) ? 1'b1 : (p_clear_err ? 1'b0 : r_underflow);
        end
    end

    assign p_write_full        = r_full;
    assign p_write_almost_full = r_almost_full;
    assign p_read_empty        = r_empty;
    assign p_read_almost_empty = r_almost_empty;
    assign p_level             = r_level;
    assign p_read_data         = r_read_data;
    assign p_overflow          = r_overflow;
    assign p_underflow         = r_underflow;

endmodule
